// File: rtl/methane_pkg.sv
// methane_pkg: shared types and constants for the instruction-memory server.
package methane_pkg;
    typedef enum reg [0:0] {S_LOAD, S_SERVE} imem_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: 2-entry response FIFO holding {err, instr}.
// Ports: clk, rst (sync, active-high); push/din write the tail; pop frees the head
// shown on dout; count/full/empty report occupancy.
module imem_resp_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [32:0] din,
    output logic [32:0] dout,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);
    logic [32:0] ent_q [2];
    logic [32:0] ent_d [2];
    logic        wr_q, wr_d, rd_q, rd_d;
    logic [1:0]  count_q, count_d;
    logic        push_ok, pop_ok;

    always_comb begin
        full    = count_q == 2'd2;
        empty   = count_q == 2'd0;
        count   = count_q;
        dout    = ent_q[rd_q];
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        ent_d   = ent_q;
        wr_d    = push_ok ? ~wr_q : wr_q;
        rd_d    = pop_ok ? ~rd_q : rd_q;
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (push_ok) ent_d[wr_q] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q   <= '{default: '0};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            ent_q   <= ent_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/imem_server.sv
// imem_server: instruction memory loaded from a byte stream, then serving fetches.
// Ports: clk, rst (sync, active-high); load_valid/load_byte/load_ready/load_done
// fill the RAM little-endian; load_overflow, loaded_words, serving report status;
// req_valid/req_ready/req_addr accept fetches; resp_valid/resp_ready/resp_instr/
// resp_err return them in order with fixed latency 2.
module imem_server
    import methane_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] NOP_INSTR  = methane_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    input  logic                  load_done,
    output logic                  load_overflow,
    output logic [ADDR_WIDTH:0]   loaded_words,
    output logic                  serving,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_instr,
    output logic                  resp_err
);
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

    imem_state_t           state_q, state_d;
    logic [1:0]            lane_q, lane_d, lane_n;
    logic [31:0]           word_q, word_d, word_n;
    logic [ADDR_WIDTH:0]   lw_q, lw_d;
    logic                  ovf_q, ovf_d;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [31:0]           rdata_q;
    logic [ADDR_WIDTH-1:0] idx, ram_addr;
    logic                  loading, byte_acc, done, we, req_acc, req_err;
    logic                  fifo_full, fifo_empty;
    logic [1:0]            fifo_count;
    logic [32:0]           fifo_dout;

    always_comb begin
        loading       = state_q == S_LOAD;
        serving       = state_q == S_SERVE;
        loaded_words  = lw_q;
        load_overflow = ovf_q;
        load_ready    = loading && (lw_q < CAP);
        byte_acc      = load_valid && load_ready;
        word_n        = word_q;
        if (byte_acc) word_n[{lane_q, 3'b000} +: 8] = load_byte;
        lane_n        = lane_q + {1'b0, byte_acc};
        done          = loading && load_done;
        // A completed word, or a trailing partial word at load_done; upper bytes
        // of a partial word are already zero because word_q clears after each write.
        we            = (byte_acc && lane_q == 2'd3) || (done && lane_n != 2'd0);
        lw_d          = lw_q + {{ADDR_WIDTH{1'b0}}, we};
        word_d        = we ? 32'd0 : word_n;
        lane_d        = we ? 2'd0 : lane_n;
        ovf_d         = ovf_q || (loading && load_valid && !load_ready);
        state_d       = done ? S_SERVE : state_q;
        idx           = req_addr[ADDR_WIDTH+1:2];
        ram_addr      = loading ? lw_q[ADDR_WIDTH-1:0] : idx;
        req_ready     = serving && !fifo_full &&
                        (({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'd2);
        req_acc       = req_valid && req_ready;
        req_err       = (req_addr[1:0] != 2'b00) || ({1'b0, idx} >= lw_q) ||
                        (req_addr[31:ADDR_WIDTH+2] != '0);
        inflight_d    = req_acc;
        err_d         = req_acc ? req_err : err_q;
        resp_valid    = !fifo_empty;
        resp_err      = fifo_dout[32];
        resp_instr    = fifo_dout[31:0];
    end

    // Single-port RAM: writes only while loading, reads only while serving.
    always_ff @(posedge clk) begin
        if (we) mem[ram_addr] <= word_n;
        if (req_acc) rdata_q <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            lane_q     <= 2'd0;
            word_q     <= 32'd0;
            lw_q       <= '0;
            ovf_q      <= 1'b0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            lw_q       <= lw_d;
            ovf_q      <= ovf_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    imem_resp_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (resp_valid && resp_ready),
        .din   ({err_q, err_q ? NOP_INSTR : rdata_q}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule
